// File: rtl/flush_ctrl.sv
// flush_ctrl -- EX-stage redirect / front-end squash controller with a
// 2-bit saturating branch-history table and a mispredict counter.
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   if_pc          in   fetch PC, indexes the BHT for prediction
//   pred_taken     out  prediction for if_pc (counter bit 1)
//   ex_valid       in   EX instruction valid
//   ex_pc          in   EX instruction PC, indexes the BHT for update
//   pc_src         in   0 seq, 1 cond branch, 2 jump, 3 jump-reg, else seq
//   branch         in   resolved branch condition
//   ex_pred        in   prediction carried with the EX instruction
//   stall          in   pipeline hold, EX instruction does not advance
//   cancel         out  redirect required this cycle
//   redirect_taken out  1 = fetch target, 0 = fetch ex_pc+4
//   squash         out  per-stage kill, bit 0 = IF
//   mispred_cnt    out  saturating count of conditional-branch mispredicts
module flush_ctrl #(
  parameter int STAGES   = 2,
  parameter int PC_SRC_W = 3,
  parameter int BHT_BITS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         if_pc,
  output logic                pred_taken,
  input  logic                ex_valid,
  input  logic [31:0]         ex_pc,
  input  logic [PC_SRC_W-1:0] pc_src,
  input  logic                branch,
  input  logic                ex_pred,
  input  logic                stall,
  output logic                cancel,
  output logic                redirect_taken,
  output logic [STAGES-1:0]   squash,
  output logic [CNT_W-1:0]    mispred_cnt
);

  localparam int ENTRIES = 1 << BHT_BITS;

  localparam logic [PC_SRC_W-1:0] SRC_BR   = PC_SRC_W'(1);
  localparam logic [PC_SRC_W-1:0] SRC_JMP  = PC_SRC_W'(2);
  localparam logic [PC_SRC_W-1:0] SRC_JMPR = PC_SRC_W'(3);

  logic [BHT_BITS-1:0] if_idx;
  logic [BHT_BITS-1:0] ex_idx;
  logic                is_br;
  logic                is_jump;
  logic                br_mispred;
  logic                bht_we;
  logic [1:0]          bht_q [ENTRIES];
  logic [1:0]          ctr_ex;
  logic [1:0]          ctr_d;
  logic                flush_pend_q;
  logic                flush_pend_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;

  // Only the word-index bits of the PCs select a BHT entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[31:BHT_BITS+2], if_pc[1:0],
                            ex_pc[31:BHT_BITS+2], ex_pc[1:0]};

  assign if_idx = if_pc[BHT_BITS+1:2];
  assign ex_idx = ex_pc[BHT_BITS+1:2];

  // Decode of the EX instruction's control flow.
  assign is_br      = ex_valid & (pc_src == SRC_BR);
  assign is_jump    = (pc_src == SRC_JMP) | (pc_src == SRC_JMPR);
  assign br_mispred = is_br & (branch != ex_pred);

  assign cancel = br_mispred | (ex_valid & is_jump);

  always_comb begin
    redirect_taken = 1'b0;
    if (pc_src == SRC_BR) begin
      redirect_taken = branch;
    end else if (is_jump) begin
      redirect_taken = 1'b1;
    end
  end

  // Squash covers the redirect cycle itself plus every cycle a stalled
  // redirect is still waiting to be released.
  assign squash = {STAGES{cancel | flush_pend_q}};

  // Prediction reads the registered table directly: an update landing on
  // the same entry this cycle is not forwarded.
  assign pred_taken = bht_q[if_idx][1];

  // Updates are suppressed while stalled so a held branch trains once.
  assign bht_we = is_br & ~stall;
  assign ctr_ex = bht_q[ex_idx];

  always_comb begin
    ctr_d = ctr_ex;
    if (branch) begin
      if (ctr_ex != 2'd3) ctr_d = ctr_ex + 2'd1;
    end else begin
      if (ctr_ex != 2'd0) ctr_d = ctr_ex - 2'd1;
    end
  end

  // One register pair per table entry; the async reset to "weakly not
  // taken" rules out a RAM macro here.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_bht
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bht_q[gi] <= 2'd1;
        end else if (bht_we && (ex_idx == BHT_BITS'(gi))) begin
          bht_q[gi] <= ctr_d;
        end
      end
    end
  endgenerate

  // Pending flush: armed by a redirect that cannot leave EX because of a
  // stall, released on the first edge the pipeline moves again.
  always_comb begin
    flush_pend_d = flush_pend_q;
    if (!stall) begin
      flush_pend_d = 1'b0;
    end else if (cancel) begin
      flush_pend_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (br_mispred && !stall && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      flush_pend_q <= flush_pend_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mispred_cnt = cnt_q;

endmodule
